// File: rtl/ft245_fifo_responder.sv
// FT245-side responder for an nRD/WR bitbang master on the same clock.
// The host stream fills the RX FIFO, which the master reads. Master writes land in the TX FIFO,
// which drains to the host stream.
module ft245_fifo_responder #(
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RXF_GAP  = 2,
    parameter int unsigned TXE_GAP  = 2
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        nRXF,
    output logic                        nTXE,
    input  logic                        nRD,
    input  logic                        WR,
    input  logic [7:0]                  D_in,
    output logic [7:0]                  D_out,
    output logic                        D_oe,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        rd_err,
    output logic                        wr_err
);

    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RGW = (RXF_GAP < 1) ? 1 : $clog2(RXF_GAP + 1);
    localparam int unsigned TGW = (TXE_GAP < 1) ? 1 : $clog2(TXE_GAP + 1);

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [7:0]     tx_mem [TX_DEPTH];

    logic [RAW:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TAW:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RGW-1:0] rgap_q, rgap_d;
    logic [TGW-1:0] tgap_q, tgap_d;
    logic           nrxf_q, nrxf_d;
    logic           ntxe_q, ntxe_d;
    logic           nrd_q, wr_q;
    logic           rd_legal_q, rd_legal_d;
    logic           rd_err_q, rd_err_d;
    logic           wr_err_q, wr_err_d;

    logic           rx_empty, rx_full, tx_empty, tx_full;
    logic           rx_empty_d, tx_full_d;
    logic           rx_push, rx_pop, tx_push, tx_pop;
    logic           rd_start, rd_rise, wr_fall;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                      (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                      (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);

    assign rd_start = nrd_q && !nRD;
    assign rd_rise  = !nrd_q && nRD;
    assign wr_fall  = wr_q && !WR;

    assign rx_ready = rst_n && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_rise && rd_legal_q && !rx_empty;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = rst_n && wr_fall && !tx_full;

    assign tx_data  = tx_mem[tx_rptr_q[TAW-1:0]];
    assign D_out    = rx_empty ? 8'hFF : rx_mem[rx_rptr_q[RAW-1:0]];
    assign D_oe     = !nRD;
    assign nRXF     = nrxf_q;
    assign nTXE     = ntxe_q;
    assign rx_level = rx_wptr_q - rx_rptr_q;
    assign tx_level = tx_wptr_q - tx_rptr_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        rd_legal_d = rd_legal_q;
        rd_err_d   = rd_err_q;
        wr_err_d   = wr_err_q;
        rgap_d     = '0;
        tgap_d     = '0;

        if (rx_push) rx_wptr_d = rx_wptr_q + (RAW+1)'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + (RAW+1)'(1);
        if (tx_push) tx_wptr_d = tx_wptr_q + (TAW+1)'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + (TAW+1)'(1);

        // A read that starts while nRXF is high is flagged and never pops.
        if (rd_start) begin
            rd_legal_d = !nrxf_q;
            if (nrxf_q) rd_err_d = 1'b1;
        end else if (rx_pop) begin
            rd_legal_d = 1'b0;
        end
        if (wr_fall && tx_full) wr_err_d = 1'b1;

        if (rx_pop)              rgap_d = RGW'(RXF_GAP);
        else if (rgap_q != '0)   rgap_d = rgap_q - RGW'(1);
        if (tx_push)             tgap_d = TGW'(TXE_GAP);
        else if (tgap_q != '0)   tgap_d = tgap_q - TGW'(1);

        // Flags use next-state occupancy so a same-cycle pop+push never flashes empty.
        rx_empty_d = (rx_wptr_d == rx_rptr_d);
        tx_full_d  = (tx_wptr_d[TAW] != tx_rptr_d[TAW]) &&
                     (tx_wptr_d[TAW-1:0] == tx_rptr_d[TAW-1:0]);
        nrxf_d     = rx_empty_d || !nRD || (rgap_d != '0);
        ntxe_d     = tx_full_d || WR || (tgap_d != '0);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rgap_q     <= '0;
            tgap_q     <= '0;
            nrxf_q     <= 1'b1;
            ntxe_q     <= 1'b1;
            rd_legal_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            nrd_q      <= nRD;
            wr_q       <= WR;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rgap_q     <= rgap_d;
            tgap_q     <= tgap_d;
            nrxf_q     <= nrxf_d;
            ntxe_q     <= ntxe_d;
            rd_legal_q <= rd_legal_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            nrd_q      <= nRD;
            wr_q       <= WR;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wptr_q[RAW-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_wptr_q[TAW-1:0]] <= D_in;
    end

endmodule

// File: doc/ft245_fifo_responder.md
Name: ft245_fifo_responder

Overview:
- Synthesizable model of the FT245 USB FIFO chip side, i.e. the responder to the FPGA's nRD/WR bitbang master.
- Host-side byte streams (e.g. from a UART or test stimulus) fill an RX FIFO that the master reads via nRXF/nRD/D.
- Bytes the master writes via nTXE/WR/D land in a TX FIFO drained on a host-side stream.
- Lets the JTAG/AS/PS bitbang logic run on-chip without a physical FT245, and serves as the verification partner for it.

Parameters:
- RX_DEPTH, 16, RX FIFO entries; power of two, >= 2
- TX_DEPTH, 16, TX FIFO entries; power of two, >= 2
- RXF_GAP, 2, cycles nRXF is held high after each pop (FT245 RXF precharge)
- TXE_GAP, 2, cycles nTXE is held high after each push (FT245 TXE precharge)

Ports:
- CLK  in  1  system clock; the master runs on the same clock
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  8  host byte to deliver to the master
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO can accept a byte
- tx_data  out  8  byte written by the master, TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  host consumes tx_data
- nRXF  out  1  active-low: a byte is readable
- nTXE  out  1  active-low: a byte can be written
- nRD  in  1  active-low read strobe from the master
- WR  in  1  active-high write strobe; data latched on its falling edge
- D_in  in  8  bus value from the master (top level ties to tri-state pad)
- D_out  out  8  bus value driven to the master
- D_oe  out  1  drive enable for D_out
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- rd_err  out  1  sticky: read strobe while nRXF high
- wr_err  out  1  sticky: write strobe while TX FIFO full

Behaviour:

Reset (rst_n low at a CLK edge):
- Both FIFOs empty; levels 0.
- nRXF=1, nTXE=1, D_oe=0, rx_ready=0, tx_valid=0, rd_err=0, wr_err=0, gap counters 0.
- Edge detectors nRD_q/WR_q load the current nRD/WR pin values, so no edge is seen on the first post-reset cycle.
- Reset mid-transaction flushes all content; a strobe still active after release is ignored until it deasserts.

Host side:
- rx_ready = !rx_full. Push on rx_valid && rx_ready.
- tx_valid = !tx_empty; tx_data = TX head. Pop on tx_valid && tx_ready.
- rx_valid while full: byte stays pending, rx_level unchanged.

Read path:
- D_out = RX head (registered FIFO output), combinational to the pin; D_oe = !nRD (combinational).
- The master samples D one cycle after driving nRD low, so data must be valid the same cycle nRD is low.
- Read start (nRD_q=1, nRD=0): if nRXF was 1, set rd_err; D_out = 8'hFF while empty; no pop.
- Pop on nRD rising edge (nRD_q=0, nRD=1), only if the read start was legal.

nRXF (registered):
- nRXF = 1 while RX empty, while nRD is low, and for RXF_GAP cycles after a pop.
- Otherwise nRXF = 0.
- A host push into an empty FIFO drops nRXF on the next cycle.

Write path:
- WR falling edge (WR_q=1, WR=0): push D_in sampled at that edge.
- If the TX FIFO is full: byte dropped, wr_err set.
- WR high duration is unconstrained; no push while WR stays high.

nTXE (registered):
- nTXE = 1 while TX full, while WR is high, and for TXE_GAP cycles after a push.
- Otherwise nTXE = 0.

Concurrency and arithmetic:
- Simultaneous push and pop on the same FIFO in one cycle is legal; level unchanged.
- Pop of the last entry and host push in the same cycle: no empty glitch visible on nRXF beyond the gap.
- Pointers wrap modulo depth; full/empty use an extra pointer MSB.
- Levels saturate naturally at DEPTH and never exceed it.
- Error flags clear only on reset.

Test Plan:
1. After reset, push 0xA5 on rx side → nRXF falls 1 cycle later; master pulses nRD low 2 cycles → D_oe=1, D_out=0xA5 during the pulse; rx_level 1→0 after nRD rises; nRXF stays high ≥RXF_GAP cycles.
2. Fill RX with 16 bytes 0x00..0x0F → rx_ready=0; 17th held pending; master reads all 16 in order; wrap verified over 40 bytes with no loss or reorder.
3. Master WR high 2 cycles with D_in=0x3C, then low → tx_valid=1, tx_data=0x3C, nTXE high TXE_GAP cycles, then low again.
4. tx_ready=0, master writes 17 bytes → nTXE=1 at 16; forced 17th write sets wr_err=1 and tx_level stays 16.
5. nRD pulse with RX empty → rd_err=1, D_out=0xFF, rx_level stays 0, no pointer movement.
6. rst_n low for 1 cycle while nRD is held low with 3 bytes queued → levels 0, nRXF=1; nRD then rising causes no pop and rd_err stays 0.
